// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage register.
// Used by pipe_slot and pipe_stage_skid.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned N_DEF  = 32;
  localparam int unsigned V_DEF  = 256;
  localparam int unsigned R_DEF  = 5;
  localparam int unsigned C_DEF  = 4;
  localparam int unsigned NS_DEF = 2;
  localparam int unsigned NV_DEF = 2;

  localparam int unsigned CTRL_PCSRC   = 0;
  localparam int unsigned CTRL_REGW    = 1;
  localparam int unsigned CTRL_REGWV   = 2;
  localparam int unsigned CTRL_MEM2REG = 3;

  localparam int unsigned STAT_W = 32;

  // Saturating increment for the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register (ctrl, scalar fields, vector fields, write address)
// with load enable and synchronous active-high clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned V  = V_DEF,
  parameter int unsigned R  = R_DEF,
  parameter int unsigned C  = C_DEF,
  parameter int unsigned NS = NS_DEF,
  parameter int unsigned NV = NV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [C-1:0]    d_ctrl,
  input  logic [NS*N-1:0] d_sdata,
  input  logic [NV*V-1:0] d_vdata,
  input  logic [R-1:0]    d_wa,
  output logic [C-1:0]    q_ctrl,
  output logic [NS*N-1:0] q_sdata,
  output logic [NV*V-1:0] q_vdata,
  output logic [R-1:0]    q_wa
);

  logic [C-1:0]    ctrl_d, ctrl_q;
  logic [NS*N-1:0] sdata_d, sdata_q;
  logic [NV*V-1:0] vdata_d, vdata_q;
  logic [R-1:0]    wa_d, wa_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    sdata_d = sdata_q;
    vdata_d = vdata_q;
    wa_d    = wa_q;
    if (load) begin
      ctrl_d  = d_ctrl;
      sdata_d = d_sdata;
      vdata_d = d_vdata;
      wa_d    = d_wa;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      sdata_q <= '0;
      vdata_q <= '0;
      wa_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      sdata_q <= sdata_d;
      vdata_q <= vdata_d;
      wa_q    <= wa_d;
    end
  end

  assign q_ctrl  = ctrl_q;
  assign q_sdata = sdata_q;
  assign q_vdata = vdata_q;
  assign q_wa    = wa_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and ctrl gating.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned V  = V_DEF,
  parameter int unsigned R  = R_DEF,
  parameter int unsigned C  = C_DEF,
  parameter int unsigned NS = NS_DEF,
  parameter int unsigned NV = NV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [C-1:0]    in_ctrl,
  input  logic [NS*N-1:0] in_sdata,
  input  logic [NV*V-1:0] in_vdata,
  input  logic [R-1:0]    in_wa,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [C-1:0]    out_ctrl,
  output logic [NS*N-1:0] out_sdata,
  output logic [NV*V-1:0] out_vdata,
  output logic [R-1:0]    out_wa
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     xfer_cnt
`endif
);

  pipe_state_t state_d, state_q;

  logic accept, pop;
  logic main_load, main_from_skid, skid_load;

  logic [C-1:0]    main_ctrl, skid_ctrl, main_d_ctrl;
  logic [NS*N-1:0] main_sdata, skid_sdata, main_d_sdata;
  logic [NV*V-1:0] main_vdata, skid_vdata, main_d_vdata;
  logic [R-1:0]    main_wa, skid_wa, main_d_wa;

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d        = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Slots keep stale data on flush; out_ctrl gating hides it.
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    main_d_ctrl  = in_ctrl;
    main_d_sdata = in_sdata;
    main_d_vdata = in_vdata;
    main_d_wa    = in_wa;
    if (main_from_skid) begin
      main_d_ctrl  = skid_ctrl;
      main_d_sdata = skid_sdata;
      main_d_vdata = skid_vdata;
      main_d_wa    = skid_wa;
    end
  end

  pipe_slot #(
    .N  (N),
    .V  (V),
    .R  (R),
    .C  (C),
    .NS (NS),
    .NV (NV)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .d_ctrl  (main_d_ctrl),
    .d_sdata (main_d_sdata),
    .d_vdata (main_d_vdata),
    .d_wa    (main_d_wa),
    .q_ctrl  (main_ctrl),
    .q_sdata (main_sdata),
    .q_vdata (main_vdata),
    .q_wa    (main_wa)
  );

  pipe_slot #(
    .N  (N),
    .V  (V),
    .R  (R),
    .C  (C),
    .NS (NS),
    .NV (NV)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .d_ctrl  (in_ctrl),
    .d_sdata (in_sdata),
    .d_vdata (in_vdata),
    .d_wa    (in_wa),
    .q_ctrl  (skid_ctrl),
    .q_sdata (skid_sdata),
    .q_vdata (skid_vdata),
    .q_wa    (skid_wa)
  );

  // A bubble must never assert a write enable downstream.
  assign out_ctrl  = main_ctrl & {C{out_valid}};
  assign out_sdata = main_sdata;
  assign out_vdata = main_vdata;
  assign out_wa    = main_wa;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;
  logic [31:0] xfer_cnt_d, xfer_cnt_q;
  logic        flush_drop;

  // An entry popped in the flush cycle is a transfer, not a drop.
  assign flush_drop = flush & ((state_q == TWO) | ((state_q == ONE) & ~out_ready) | accept);

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, out_valid & ~out_ready);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_drop);
    xfer_cnt_d  = sat_inc(xfer_cnt_q, pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule
